// File: rtl/gbc_video_memory_target.sv
// gbc_video_memory_target
//   Wishbone pipelined target behind the memory bus's VideoRAM initiator port.
//   Owns VRAM (two 8 KiB banks, ADDR_I[13] selects the bank), OAM and the PPU
//   register file FF40-FF4B. Serves CPU accesses with PPU-mode lockout, and
//   OAM-DMA beats either from bus data or as a VRAM->OAM copy.
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   CYC_I STB_I WE_I      Wishbone cycle / strobe / write enable
//   ADDR_I DAT_I          byte address within the space, write data
//   TGA_I                 space: 00 VRAM, 01 OAM, 10 registers, 11 unmapped
//   TGC_I                 0 CPU access, 1 OAM-DMA beat
//   STALL_O ACK_O DAT_O   stall, one-cycle ack, read data (valid with ACK_O)
//   ppu_mode_i ly_i       PPU STAT mode and current scanline
//   lcdc_o .. bgp_o       register contents driven to the PPU
module gbc_video_memory_target #(
   parameter int OAM_BYTES = 160,
   parameter int VRAM_AW   = 14
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               CYC_I,
   input  logic               STB_I,
   input  logic               WE_I,
   input  logic [VRAM_AW-1:0] ADDR_I,
   input  logic [7:0]         DAT_I,
   input  logic [1:0]         TGA_I,
   input  logic               TGC_I,
   output logic               STALL_O,
   output logic               ACK_O,
   output logic [7:0]         DAT_O,
   input  logic [1:0]         ppu_mode_i,
   input  logic [7:0]         ly_i,
   output logic [7:0]         lcdc_o,
   output logic [7:0]         scy_o,
   output logic [7:0]         scx_o,
   output logic [7:0]         wy_o,
   output logic [7:0]         wx_o,
   output logic [7:0]         bgp_o
);

   typedef enum logic [1:0] {IDLE, COPY_RD, COPY_WR} state_t;

   localparam logic [8:0] OAM_LIM = 9'(OAM_BYTES);

   state_t             state;
   logic               ack_q;
   logic [7:0]         dat_q;

   // VRAM->OAM copy context
   logic [VRAM_AW-1:0] cp_addr;
   logic [7:0]         cp_idx;
   logic [7:0]         cp_data;
   logic               cp_lost;    // CYC_I dropped during the copy: no ACK

   // register file
   logic [7:0] lcdc, scy, scx, lyc, bgp, obp0, obp1, wy, wx;
   logic [3:0] stat_w;

   logic [7:0] vram [2**VRAM_AW];
   logic [7:0] oam  [OAM_BYTES];

   logic       accept, is_copy, lock_vram, lock_oam, oam_hit, cp_hit;
   logic       vram_we, oam_we, reg_we;
   logic [7:0] idx, reg_rd, rd_data;

   assign STALL_O   = (state == COPY_RD) || (state == COPY_WR);
   assign accept    = CYC_I & STB_I & ~STALL_O;
   assign idx       = ADDR_I[7:0];
   assign is_copy   = TGC_I & (TGA_I == 2'b00);
   // lockout applies only to CPU accesses; DMA beats ignore PPU mode
   assign lock_vram = ~TGC_I & (ppu_mode_i == 2'd3);
   assign lock_oam  = ~TGC_I & ppu_mode_i[1];
   assign oam_hit   = {1'b0, idx} < OAM_LIM;
   assign cp_hit    = {1'b0, cp_idx} < OAM_LIM;

   assign vram_we = accept & WE_I & (TGA_I == 2'b00) & ~TGC_I & ~lock_vram;
   // DMA-from-bus beats write OAM regardless of WE_I
   assign oam_we  = accept & (TGA_I == 2'b01) & oam_hit & (TGC_I | (WE_I & ~lock_oam));
   assign reg_we  = accept & WE_I & (TGA_I == 2'b10);

   assign ACK_O  = ack_q & CYC_I;
   assign DAT_O  = dat_q;
   assign lcdc_o = lcdc;
   assign scy_o  = scy;
   assign scx_o  = scx;
   assign wy_o   = wy;
   assign wx_o   = wx;
   assign bgp_o  = bgp;

   always_comb begin
      reg_rd = 8'hFF;
      case (idx)
         8'h40:   reg_rd = lcdc;
         8'h41:   reg_rd = {1'b1, stat_w, (ly_i == lyc), ppu_mode_i};
         8'h42:   reg_rd = scy;
         8'h43:   reg_rd = scx;
         8'h44:   reg_rd = ly_i;
         8'h45:   reg_rd = lyc;
         8'h47:   reg_rd = bgp;
         8'h48:   reg_rd = obp0;
         8'h49:   reg_rd = obp1;
         8'h4A:   reg_rd = wy;
         8'h4B:   reg_rd = wx;
         default: reg_rd = 8'hFF;
      endcase
   end

   // Response data for single-cycle accesses; writes return the old contents,
   // DMA-from-bus beats echo the byte written.
   always_comb begin
      rd_data = 8'hFF;
      case (TGA_I)
         2'b00: if (!lock_vram) rd_data = vram[ADDR_I];
         2'b01: begin
            if (TGC_I)                    rd_data = DAT_I;
            else if (!lock_oam && oam_hit) rd_data = oam[idx];
         end
         2'b10:   rd_data = reg_rd;
         default: rd_data = 8'hFF;
      endcase
   end

   // RAM arrays carry no reset
   always_ff @(posedge CLK) begin
      if (vram_we) vram[ADDR_I] <= DAT_I;
      if (state == COPY_WR && cp_hit) oam[cp_idx] <= cp_data;
      else if (oam_we)                oam[idx]    <= DAT_I;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         ack_q   <= 1'b0;
         dat_q   <= 8'h00;
         cp_addr <= '0;
         cp_idx  <= 8'h00;
         cp_data <= 8'h00;
         cp_lost <= 1'b0;
         lcdc    <= 8'h91;
         stat_w  <= 4'h0;
         scy     <= 8'h00;
         scx     <= 8'h00;
         lyc     <= 8'h00;
         bgp     <= 8'hFC;
         obp0    <= 8'h00;
         obp1    <= 8'h00;
         wy      <= 8'h00;
         wx      <= 8'h00;
      end else begin
         ack_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_copy) begin
                     // the beat's address is the VRAM source; its low byte
                     // doubles as the OAM destination index
                     state   <= COPY_RD;
                     cp_addr <= ADDR_I;
                     cp_idx  <= idx;
                     cp_lost <= 1'b0;
                  end else begin
                     ack_q <= 1'b1;
                     dat_q <= rd_data;
                  end
               end
            end
            COPY_RD: begin
               cp_data <= vram[cp_addr];
               cp_lost <= cp_lost | ~CYC_I;
               state   <= COPY_WR;
            end
            COPY_WR: begin
               ack_q <= CYC_I & ~cp_lost;
               dat_q <= cp_data;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (reg_we) begin
            case (idx)
               8'h40:   lcdc   <= DAT_I;
               8'h41:   stat_w <= DAT_I[6:3];
               8'h42:   scy    <= DAT_I;
               8'h43:   scx    <= DAT_I;
               8'h45:   lyc    <= DAT_I;
               8'h47:   bgp    <= DAT_I;
               8'h48:   obp0   <= DAT_I;
               8'h49:   obp1   <= DAT_I;
               8'h4A:   wy     <= DAT_I;
               8'h4B:   wx     <= DAT_I;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gbc_video_memory_target.sv
// Directed bench for gbc_video_memory_target. Inputs change on the falling
// edge, outputs are sampled on the falling edge after each rising edge.
module tb_gbc_video_memory_target;

   logic        CLK = 1'b0;
   logic        RST_N, CYC_I, STB_I, WE_I, TGC_I;
   logic [13:0] ADDR_I;
   logic [7:0]  DAT_I, ly_i;
   logic [1:0]  TGA_I, ppu_mode_i;
   logic        STALL_O, ACK_O;
   logic [7:0]  DAT_O, lcdc_o, scy_o, scx_o, wy_o, wx_o, bgp_o;

   int total = 0;
   int bad   = 0;
   logic       a;
   logic [7:0] d;

   always #5 CLK = ~CLK;

   gbc_video_memory_target dut (
      .CLK(CLK), .RST_N(RST_N), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
      .ADDR_I(ADDR_I), .DAT_I(DAT_I), .TGA_I(TGA_I), .TGC_I(TGC_I),
      .STALL_O(STALL_O), .ACK_O(ACK_O), .DAT_O(DAT_O),
      .ppu_mode_i(ppu_mode_i), .ly_i(ly_i),
      .lcdc_o(lcdc_o), .scy_o(scy_o), .scx_o(scx_o), .wy_o(wy_o), .wx_o(wx_o),
      .bgp_o(bgp_o)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] tga, input logic tgc,
                        input logic [13:0] addr, input logic [7:0] dat);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; TGA_I = tga; TGC_I = tgc;
      ADDR_I = addr; DAT_I = dat;
   endtask

   // one single-cycle transfer: drive, let it be accepted, sample the ACK cycle
   task automatic xfer(input logic we, input logic [1:0] tga, input logic tgc,
                       input logic [13:0] addr, input logic [7:0] dat,
                       output logic ack, output logic [7:0] rd);
      @(negedge CLK);
      drive(we, tga, tgc, addr, dat);
      @(negedge CLK);
      ack = ACK_O; rd = DAT_O;
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; TGC_I = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [1:0] tga, input logic [13:0] addr,
                     input logic [7:0] dat);
      logic       k;
      logic [7:0] r;
      xfer(1'b1, tga, 1'b0, addr, dat, k, r);
      chk(tag, {7'd0, k}, 8'h01);
   endtask

   task automatic rd(input string tag, input logic [1:0] tga, input logic [13:0] addr,
                     input logic [7:0] exp);
      logic       k;
      logic [7:0] r;
      xfer(1'b0, tga, 1'b0, addr, 8'h00, k, r);
      chk({tag, "_ack"}, {7'd0, k}, 8'h01);
      chk(tag, r, exp);
   endtask

   initial begin
      RST_N = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; TGC_I = 1'b0;
      TGA_I = 2'b00; ADDR_I = '0; DAT_I = '0; ppu_mode_i = 2'd0; ly_i = 8'h00;
      repeat (2) @(negedge CLK);
      chk("rst_stall", {7'd0, STALL_O}, 8'h00);
      chk("rst_ack",   {7'd0, ACK_O},   8'h00);
      chk("rst_dat",   DAT_O,  8'h00);
      chk("rst_lcdc",  lcdc_o, 8'h91);
      chk("rst_bgp",   bgp_o,  8'hFC);
      chk("rst_scy",   scy_o,  8'h00);
      chk("rst_wx",    wx_o,   8'h00);
      RST_N = 1'b1;

      // VRAM banks
      wr("vram_w_b1", 2'b00, 14'h2005, 8'h3C);
      wr("vram_w_b0", 2'b00, 14'h0005, 8'h11);
      rd("vram_r_b1", 2'b00, 14'h2005, 8'h3C);
      rd("vram_r_b0", 2'b00, 14'h0005, 8'h11);

      // lockout
      wr("vram_w_old", 2'b00, 14'h0010, 8'h22);
      ppu_mode_i = 2'd3;
      wr("vram_w_lock", 2'b00, 14'h0010, 8'h55);
      rd("vram_r_lock", 2'b00, 14'h0010, 8'hFF);
      ppu_mode_i = 2'd0;
      rd("vram_r_kept", 2'b00, 14'h0010, 8'h22);
      wr("oam_w5", 2'b01, 14'h0005, 8'h66);
      ppu_mode_i = 2'd2;
      rd("oam_r_lock2", 2'b01, 14'h0005, 8'hFF);
      ppu_mode_i = 2'd3;
      wr("oam_w_lock3", 2'b01, 14'h0005, 8'h77);
      ppu_mode_i = 2'd0;
      rd("oam_r_kept", 2'b01, 14'h0005, 8'h66);
      rd("oam_r_oob", 2'b01, 14'h00C8, 8'hFF);

      // registers
      wr("reg_w_scy", 2'b10, 14'h0042, 8'h12);
      chk("scy_o", scy_o, 8'h12);
      wr("reg_w_lyc", 2'b10, 14'h0045, 8'h90);
      ly_i = 8'h90; ppu_mode_i = 2'd1;
      rd("stat_eq", 2'b10, 14'h0041, 8'h85);
      wr("reg_w_stat", 2'b10, 14'h0041, 8'hFF);
      ly_i = 8'h91;
      rd("stat_ne", 2'b10, 14'h0041, 8'hF9);
      rd("reg_ly", 2'b10, 14'h0044, 8'h91);
      wr("reg_w_ly", 2'b10, 14'h0044, 8'h33);
      rd("reg_ly_ro", 2'b10, 14'h0044, 8'h91);
      rd("reg_4c", 2'b10, 14'h004C, 8'hFF);
      wr("reg_w_wx", 2'b10, 14'h004B, 8'h07);
      chk("wx_o", wx_o, 8'h07);
      wr("reg_w_lcdc", 2'b10, 14'h0040, 8'h00);
      chk("lcdc_o", lcdc_o, 8'h00);
      rd("unmapped", 2'b11, 14'h0040, 8'hFF);
      ppu_mode_i = 2'd0;

      // DMA beat from bus data, in mode 3
      ppu_mode_i = 2'd3;
      xfer(1'b0, 2'b01, 1'b1, 14'h0007, 8'h5A, a, d);
      chk("dmab_ack", {7'd0, a}, 8'h01);
      chk("dmab_dat", d, 8'h5A);
      ppu_mode_i = 2'd0;
      rd("dmab_oam7", 2'b01, 14'h0007, 8'h5A);

      // VRAM->OAM copy in mode 3: source VRAM 0003, destination OAM[3]
      wr("cp_src", 2'b00, 14'h0003, 8'hA7);
      ppu_mode_i = 2'd3;
      @(negedge CLK);
      drive(1'b1, 2'b00, 1'b1, 14'h0003, 8'h00);
      @(negedge CLK);
      STB_I = 1'b0;
      chk("cp_stall1", {7'd0, STALL_O}, 8'h01);
      chk("cp_noack1", {7'd0, ACK_O},   8'h00);
      @(negedge CLK);
      chk("cp_stall2", {7'd0, STALL_O}, 8'h01);
      @(negedge CLK);
      chk("cp_stall_end", {7'd0, STALL_O}, 8'h00);
      chk("cp_ack", {7'd0, ACK_O}, 8'h01);
      chk("cp_dat", DAT_O, 8'hA7);
      CYC_I = 1'b0; TGC_I = 1'b0;
      ppu_mode_i = 2'd0;
      rd("cp_oam3", 2'b01, 14'h0003, 8'hA7);

      // pipelined OAM reads
      wr("pl_w0", 2'b01, 14'h0000, 8'h10);
      wr("pl_w1", 2'b01, 14'h0001, 8'h21);
      wr("pl_w2", 2'b01, 14'h0002, 8'h32);
      wr("pl_w3", 2'b01, 14'h0003, 8'h43);
      @(negedge CLK);
      drive(1'b0, 2'b01, 1'b0, 14'h0000, 8'h00);
      @(negedge CLK);
      chk("pl_ack0", {7'd0, ACK_O}, 8'h01); chk("pl_dat0", DAT_O, 8'h10);
      ADDR_I = 14'h0001;
      @(negedge CLK);
      chk("pl_ack1", {7'd0, ACK_O}, 8'h01); chk("pl_dat1", DAT_O, 8'h21);
      ADDR_I = 14'h0002;
      @(negedge CLK);
      chk("pl_ack2", {7'd0, ACK_O}, 8'h01); chk("pl_dat2", DAT_O, 8'h32);
      ADDR_I = 14'h0003;
      @(negedge CLK);
      chk("pl_ack3", {7'd0, ACK_O}, 8'h01); chk("pl_dat3", DAT_O, 8'h43);
      CYC_I = 1'b0; STB_I = 1'b0;

      // copy inserted mid-stream: VRAM 2005 (3C) -> OAM[5]
      @(negedge CLK);
      drive(1'b0, 2'b01, 1'b0, 14'h0000, 8'h00);
      @(negedge CLK);
      chk("ms_dat0", DAT_O, 8'h10);
      drive(1'b0, 2'b00, 1'b1, 14'h2005, 8'h00);
      @(negedge CLK);
      chk("ms_stall1", {7'd0, STALL_O}, 8'h01);
      chk("ms_noack1", {7'd0, ACK_O}, 8'h00);
      drive(1'b0, 2'b01, 1'b0, 14'h0002, 8'h00);
      @(negedge CLK);
      chk("ms_stall2", {7'd0, STALL_O}, 8'h01);
      chk("ms_noack2", {7'd0, ACK_O}, 8'h00);
      @(negedge CLK);
      chk("ms_stall_end", {7'd0, STALL_O}, 8'h00);
      chk("ms_cp_ack", {7'd0, ACK_O}, 8'h01);
      chk("ms_cp_dat", DAT_O, 8'h3C);
      @(negedge CLK);
      STB_I = 1'b0;
      chk("ms_ack2", {7'd0, ACK_O}, 8'h01);
      chk("ms_dat2", DAT_O, 8'h32);
      CYC_I = 1'b0;
      rd("ms_oam5", 2'b01, 14'h0005, 8'h3C);

      // CYC_I dropped during the copy: copy finishes, no ACK
      @(negedge CLK);
      drive(1'b0, 2'b00, 1'b1, 14'h0010, 8'h00);
      @(negedge CLK);
      CYC_I = 1'b0; STB_I = 1'b0;
      @(negedge CLK);
      CYC_I = 1'b1;
      @(negedge CLK);
      chk("drop_noack", {7'd0, ACK_O}, 8'h00);
      chk("drop_idle", {7'd0, STALL_O}, 8'h00);
      CYC_I = 1'b0; TGC_I = 1'b0;
      rd("drop_oam16", 2'b01, 14'h0010, 8'h22);

      // reset in COPY_RD
      @(negedge CLK);
      drive(1'b0, 2'b00, 1'b1, 14'h0003, 8'h00);
      @(negedge CLK);
      STB_I = 1'b0;
      chk("rr_stall", {7'd0, STALL_O}, 8'h01);
      RST_N = 1'b0;
      #1;
      chk("rr_ack",   {7'd0, ACK_O},   8'h00);
      chk("rr_stall0", {7'd0, STALL_O}, 8'h00);
      chk("rr_lcdc",  lcdc_o, 8'h91);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("rr_noack", {7'd0, ACK_O}, 8'h00);
      CYC_I = 1'b0; TGC_I = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
